mfcc_melbank_coef_reader: RTL and testbench

Read-side sequencer for the MFCC mel filterbank coefficient ROMs. It drives the ROM address and captures the returned words, whether the ROM output is registered or not. It streams the requested run of coefficients to the mel-energy MAC over a valid/ready interface with full backpressure support. One instance sits in front of each melbank ROM.

---
 rtl/mfcc_pkg.sv | 15 +
 rtl/mfcc_coef_fifo2.sv | 58 +++++
 rtl/mfcc_melbank_coef_reader.sv | 132 +++++++++++++
 tb/tb_mfcc_melbank_coef_reader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared constants and state encoding for the MFCC melbank coefficient readers.
// Every melbank ROM reader imports this package so they agree on ROM geometry.
package mfcc_pkg;

    localparam int MEL_ADDR_WIDTH = 4;
    localparam int MEL_DATA_WIDTH = 16;
    localparam int MEL_ROM_LAT    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } mel_rd_state_t;

endpackage

// File: rtl/mfcc_coef_fifo2.sv
// Two-entry {data, last} FIFO that sits between the ROM capture point and the MAC.
// The head entry is presented combinationally; push and pop in one cycle keep occupancy.
module mfcc_coef_fifo2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_data [2];
    logic                  mem_last [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  do_pop;

    assign do_pop = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/mfcc_melbank_coef_reader.sv
// Read sequencer for one melbank coefficient ROM: issues a run of addresses and
// streams the returned words to the mel-energy MAC over valid/ready.
module mfcc_melbank_coef_reader
    import mfcc_pkg::*;
#(
    parameter int ADDR_WIDTH = MEL_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEL_DATA_WIDTH,
    parameter int ROM_LAT    = MEL_ROM_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] coef_data,
    output logic                  coef_valid,
    input  logic                  coef_ready,
    output logic                  coef_last
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    mel_rd_state_t         state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH-1:0] issue_cnt;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  done_p1;
    logic                  accept;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic                  push_last;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  inflight;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            occ;
    logic [2:0]            occ_sum;

    // A start landing in the done cycle belongs to the finished run and is dropped.
    assign accept = (state == IDLE) && start && !done_p1;
    assign pop    = coef_valid && coef_ready;

    // Occupancy counts buffered words plus the read still in flight from the ROM.
    assign occ     = {fifo_full, !fifo_empty && !fifo_full};
    assign occ_sum = {1'b0, occ} + {2'b00, inflight};
    assign issue   = (state == FETCH) && (occ_sum < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            issue_cnt <= '0;
            addr_hold <= '0;
            done_p1   <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_p1 <= (state == DRAIN) && pop && coef_last;
            if (accept) begin
                addr_cnt  <= base_addr;
                issue_cnt <= len_m1;
            end else if (issue) begin
                addr_cnt  <= addr_cnt + ONE;
                issue_cnt <= issue_cnt - ONE;
                addr_hold <= addr_cnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   if (issue && (issue_cnt == '0)) state_nxt = DRAIN;
            DRAIN:   if (pop && coef_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    generate
        if (ROM_LAT == 0) begin : g_comb_rom
            assign inflight  = 1'b0;
            assign push      = issue;
            assign push_last = (issue_cnt == '0);
            assign push_data = rom_data;
        end else begin : g_reg_rom
            logic tag_p1;
            logic last_p1;

            // ---- issue -> ROM output register boundary ----
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_p1  <= 1'b0;
                    last_p1 <= 1'b0;
                end else begin
                    tag_p1  <= issue;
                    last_p1 <= issue && (issue_cnt == '0);
                end
            end

            assign inflight  = tag_p1;
            assign push      = tag_p1;
            assign push_last = last_p1;
            assign push_data = rom_data;
        end
    endgenerate

    mfcc_coef_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .pop       (pop),
        .head_data (coef_data),
        .head_last (coef_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign coef_valid = !fifo_empty;
    assign busy       = (state != IDLE);
    assign done       = done_p1;
    assign rom_addr   = issue ? addr_cnt : addr_hold;

endmodule

// File: tb/tb_mfcc_melbank_coef_reader.sv
// Bench for the melbank coefficient reader: a combinational-ROM and a registered-ROM
// instance run side by side against a list-based model of the expected coefficient run.
module tb_mfcc_melbank_coef_reader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_s [2];
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len_m1;
    logic          coef_ready;
    logic          busy_o  [2];
    logic          done_o  [2];
    logic          valid_o [2];
    logic          last_o  [2];
    logic [AW-1:0] addr_o  [2];
    logic [DW-1:0] data_o  [2];
    logic [DW-1:0] rom_mem [16];
    logic [DW-1:0] rom_d0;
    logic [DW-1:0] rom_q1;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] obs_data [2][32];
    bit            obs_last [2][32];
    int            obs_tcyc [2][32];
    int            obs_n [2];
    int            first_v [2];
    int            done_cyc [2];
    int            done_cnt [2];
    int            busy_cnt [2];
    int            stall_bad [2];
    int            ahead_bad [2];
    bit            busy_at_done [2];

    always #5 clk = ~clk;

    assign rom_d0 = rom_mem[addr_o[0]];
    always @(posedge clk) rom_q1 <= rom_mem[addr_o[1]];

    mfcc_melbank_coef_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .base_addr(base_addr), .len_m1(len_m1),
        .busy(busy_o[0]), .done(done_o[0]), .rom_addr(addr_o[0]), .rom_data(rom_d0),
        .coef_data(data_o[0]), .coef_valid(valid_o[0]), .coef_ready(coef_ready),
        .coef_last(last_o[0])
    );

    mfcc_melbank_coef_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .base_addr(base_addr), .len_m1(len_m1),
        .busy(busy_o[1]), .done(done_o[1]), .rom_addr(addr_o[1]), .rom_data(rom_q1),
        .coef_data(data_o[1]), .coef_valid(valid_o[1]), .coef_ready(coef_ready),
        .coef_last(last_o[1])
    );

    // Drives one run into both instances and records what each one delivers.
    // rmode: 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random ready.
    task automatic do_run(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input int rmode, input bit noise);
        bit            fin [2];
        bit            stl [2];
        logic [DW-1:0] pd  [2];
        bit            pl  [2];
        bit            pat [6] = '{1, 0, 0, 1, 0, 1};
        logic [AW-1:0] dlt;
        for (int k = 0; k < 2; k++) begin
            obs_n[k] = 0; first_v[k] = -1; done_cyc[k] = -1; done_cnt[k] = 0;
            busy_cnt[k] = 0; stall_bad[k] = 0; ahead_bad[k] = 0; busy_at_done[k] = 0;
            fin[k] = 0; stl[k] = 0; pd[k] = '0; pl[k] = 0;
        end
        @(negedge clk);
        base_addr = b; len_m1 = l; start_s[0] = 1'b1; start_s[1] = 1'b1; coef_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 300 && !(fin[0] && fin[1]); cyc++) begin
            @(negedge clk);
            start_s[0] = 1'b0; start_s[1] = 1'b0;
            case (rmode)
                0:       coef_ready = 1'b1;
                1:       coef_ready = pat[cyc % 6];
                default: coef_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            for (int k = 0; k < 2; k++) begin
                if (stl[k] && (!valid_o[k] || data_o[k] !== pd[k] || last_o[k] !== pl[k]))
                    stall_bad[k]++;
                if (valid_o[k] && first_v[k] < 0) first_v[k] = cyc;
                if (busy_o[k]) begin
                    busy_cnt[k]++;
                    dlt = addr_o[k] - b;
                    if (int'(dlt) - obs_n[k] > 2) ahead_bad[k]++;
                end
                if (done_o[k]) begin
                    done_cnt[k]++;
                    if (done_cyc[k] < 0) begin
                        done_cyc[k] = cyc;
                        busy_at_done[k] = busy_o[k];
                    end
                end
                if (valid_o[k] && coef_ready && obs_n[k] < 32) begin
                    obs_data[k][obs_n[k]] = data_o[k];
                    obs_last[k][obs_n[k]] = last_o[k];
                    obs_tcyc[k][obs_n[k]] = cyc;
                    obs_n[k]++;
                end
                stl[k] = valid_o[k] && !coef_ready;
                pd[k]  = data_o[k];
                pl[k]  = last_o[k];
                if (done_cyc[k] >= 0 && cyc >= done_cyc[k] + 2) fin[k] = 1;
                if (noise && done_o[k])      start_s[k] = 1'b1;
                else if (noise && busy_o[k]) start_s[k] = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                base_addr = AW'($urandom);
                len_m1    = AW'($urandom);
            end
        end
        start_s[0] = 1'b0; start_s[1] = 1'b0; coef_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_s[0] = 1'b0; start_s[1] = 1'b0;
        base_addr = '0; len_m1 = '0; coef_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({busy_o[k], done_o[k], valid_o[k], last_o[k]} !== 4'b0000 || addr_o[k] !== '0) begin
                bad++;
                $display("FAIL reset_ctrl lat%0d: busy=%b done=%b valid=%b last=%b addr=%0d, want all 0",
                         k, busy_o[k], done_o[k], valid_o[k], last_o[k], addr_o[k]);
            end
            total++;
            if (data_o[k] !== '0) begin
                bad++;
                $display("FAIL reset_data lat%0d: got %h want 0", k, data_o[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed_runs();
        logic [AW-1:0] tb_b [4] = '{4'd3, 4'd14, 4'd0, 4'd0};
        logic [AW-1:0] tb_l [4] = '{4'd4, 4'd3, 4'd0, 4'd15};
        bit            tb_n [4] = '{0, 0, 1, 1};
        logic [AW-1:0] a;
        int            n;
        for (int i = 0; i < 16; i++) rom_mem[i] = DW'(i);
        for (int t = 0; t < 4; t++) begin
            do_run(tb_b[t], tb_l[t], 0, tb_n[t]);
            n = int'(tb_l[t]) + 1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_n[k] != n) begin
                    bad++;
                    $display("FAIL run%0d_lat%0d_beats: got %0d want %0d", t, k, obs_n[k], n);
                end
                for (int j = 0; j < n && j < obs_n[k]; j++) begin
                    a = tb_b[t] + AW'(j);
                    total++;
                    if (obs_data[k][j] !== rom_mem[a] || obs_last[k][j] != (j == n - 1) ||
                        obs_tcyc[k][j] != 2 + k + j) begin
                        bad++;
                        $display("FAIL run%0d_lat%0d_beat%0d: data=%0d last=%0b cyc=%0d want data=%0d last=%0b cyc=%0d",
                                 t, k, j, obs_data[k][j], obs_last[k][j], obs_tcyc[k][j],
                                 rom_mem[a], (j == n - 1), 2 + k + j);
                    end
                end
                total++;
                if (first_v[k] != 2 + k) begin
                    bad++;
                    $display("FAIL run%0d_lat%0d_first_valid: got %0d want %0d", t, k, first_v[k], 2 + k);
                end
                total++;
                if (done_cyc[k] != 2 + k + n || done_cnt[k] != 1 || busy_at_done[k]) begin
                    bad++;
                    $display("FAIL run%0d_lat%0d_done: cyc=%0d count=%0d busy=%0b want cyc=%0d count=1 busy=0",
                             t, k, done_cyc[k], done_cnt[k], busy_at_done[k], 2 + k + n);
                end
                total++;
                if (busy_cnt[k] != 1 + k + n) begin
                    bad++;
                    $display("FAIL run%0d_lat%0d_busy_len: got %0d want %0d", t, k, busy_cnt[k], 1 + k + n);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] b, l, a;
        int            n;
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 16; i++) rom_mem[i] = DW'($urandom);
            b = AW'($urandom);
            l = (r == 0) ? AW'(7) : AW'($urandom);
            do_run(b, l, (r == 0) ? 1 : 2, r[0]);
            n = int'(l) + 1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_n[k] != n) begin
                    bad++;
                    $display("FAIL bp%0d_lat%0d_beats: got %0d want %0d", r, k, obs_n[k], n);
                end
                for (int j = 0; j < n && j < obs_n[k]; j++) begin
                    a = b + AW'(j);
                    total++;
                    if (obs_data[k][j] !== rom_mem[a] || obs_last[k][j] != (j == n - 1)) begin
                        bad++;
                        $display("FAIL bp%0d_lat%0d_beat%0d: data=%h last=%0b want data=%h last=%0b",
                                 r, k, j, obs_data[k][j], obs_last[k][j], rom_mem[a], (j == n - 1));
                    end
                end
                total++;
                if (first_v[k] != 2 + k) begin
                    bad++;
                    $display("FAIL bp%0d_lat%0d_first_valid: got %0d want %0d", r, k, first_v[k], 2 + k);
                end
                if (obs_n[k] > 0) begin
                    total++;
                    if (done_cyc[k] != obs_tcyc[k][obs_n[k] - 1] + 1 || done_cnt[k] != 1 ||
                        busy_cnt[k] != done_cyc[k] - 1) begin
                        bad++;
                        $display("FAIL bp%0d_lat%0d_done: cyc=%0d count=%0d busy=%0d want cyc=%0d count=1 busy=%0d",
                                 r, k, done_cyc[k], done_cnt[k], busy_cnt[k],
                                 obs_tcyc[k][obs_n[k] - 1] + 1, obs_tcyc[k][obs_n[k] - 1]);
                    end
                end
                total++;
                if (stall_bad[k] != 0 || ahead_bad[k] != 0) begin
                    bad++;
                    $display("FAIL bp%0d_lat%0d_stall_ahead: unstable=%0d ahead=%0d want 0 0",
                             r, k, stall_bad[k], ahead_bad[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int spur [2];
        for (int i = 0; i < 16; i++) rom_mem[i] = DW'(i);
        @(negedge clk);
        base_addr = 4'd9; len_m1 = 4'd7; start_s[0] = 1'b1; start_s[1] = 1'b1; coef_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({busy_o[k], done_o[k], valid_o[k], last_o[k]} !== 4'b0000 ||
                addr_o[k] !== '0 || data_o[k] !== '0) begin
                bad++;
                $display("FAIL midrst_lat%0d_outputs: busy=%b done=%b valid=%b last=%b addr=%0d data=%0d want all 0",
                         k, busy_o[k], done_o[k], valid_o[k], last_o[k], addr_o[k], data_o[k]);
            end
            spur[k] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                if (done_o[k] || busy_o[k] || valid_o[k]) spur[k]++;
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (spur[k] != 0) begin
                bad++;
                $display("FAIL midrst_lat%0d_quiet: %0d active cycles after reset, want 0", k, spur[k]);
            end
        end
        do_run(4'd0, 4'd1, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_n[k] != 2 || obs_data[k][0] !== 16'd0 || obs_data[k][1] !== 16'd1 ||
                obs_last[k][0] || !obs_last[k][1]) begin
                bad++;
                $display("FAIL midrst_lat%0d_rerun: beats=%0d d0=%0d d1=%0d last=%0b%0b want 2 0 1 01",
                         k, obs_n[k], obs_data[k][0], obs_data[k][1], obs_last[k][0], obs_last[k][1]);
            end
            total++;
            if (done_cyc[k] != 4 + k || done_cnt[k] != 1) begin
                bad++;
                $display("FAIL midrst_lat%0d_done: cyc=%0d count=%0d want cyc=%0d count=1",
                         k, done_cyc[k], done_cnt[k], 4 + k);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = DW'(i);
        test_reset();
        test_directed_runs();
        test_backpressure();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
